// File: rtl/regfile_wb_arbiter_if.sv
// Writeback arbiter bus: two requester handshakes, the registered write port, and decode hazard lookup.
// slave is the arbiter side; master is the requester/regfile/decode side.
interface regfile_wb_arbiter_if #(
    parameter int PROC_DATA_WIDTH        = 16,
    parameter int PROC_REGFILE_LOG2_DEEP = 5
);
    logic                              req0_valid_i;
    logic                              req0_ready_o;
    logic [PROC_REGFILE_LOG2_DEEP-1:0] req0_addr_i;
    logic [PROC_DATA_WIDTH-1:0]        req0_data_i;
    logic                              req1_valid_i;
    logic                              req1_ready_o;
    logic [PROC_REGFILE_LOG2_DEEP-1:0] req1_addr_i;
    logic [PROC_DATA_WIDTH-1:0]        req1_data_i;
    logic                              write_en_o;
    logic [PROC_REGFILE_LOG2_DEEP-1:0] write_addr_o;
    logic [PROC_DATA_WIDTH-1:0]        write_data_o;
    logic [PROC_REGFILE_LOG2_DEEP-1:0] read_addr1_i;
    logic [PROC_REGFILE_LOG2_DEEP-1:0] read_addr2_i;
    logic                              hazard1_o;
    logic                              hazard2_o;

    modport slave (
        input  req0_valid_i, req0_addr_i, req0_data_i,
        input  req1_valid_i, req1_addr_i, req1_data_i,
        input  read_addr1_i, read_addr2_i,
        output req0_ready_o, req1_ready_o,
        output write_en_o, write_addr_o, write_data_o,
        output hazard1_o, hazard2_o
    );

    modport master (
        output req0_valid_i, req0_addr_i, req0_data_i,
        output req1_valid_i, req1_addr_i, req1_data_i,
        output read_addr1_i, read_addr2_i,
        input  req0_ready_o, req1_ready_o,
        input  write_en_o, write_addr_o, write_data_o,
        input  hazard1_o, hazard2_o
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Two one-entry writeback holds sharing one registered regfile write port, oldest-first then round-robin.
// Latency 1 cycle uncontended (+1 per lost arbitration); reqN_ready_o = !holdN_occ | grantN, low in reset.
module regfile_wb_arbiter #(
    parameter int PROC_DATA_WIDTH        = 16,
    parameter int PROC_REGFILE_LOG2_DEEP = 5
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    regfile_wb_arbiter_if.slave  wb
);
    localparam int AW = PROC_REGFILE_LOG2_DEEP;
    localparam int DW = PROC_DATA_WIDTH;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } hold_t;

    hold_t         hold0_q, hold0_d, hold1_q, hold1_d;
    logic          occ0_q, occ0_d, occ1_q, occ1_d;
    logic          age0_q, age0_d, age1_q, age1_d;
    logic          rr_q, rr_d;
    logic          we_q, we_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [DW-1:0] wdata_q, wdata_d;

    logic grant0, grant1, same_age;
    logic rdy0, rdy1, cap0, cap1, stay0, stay1;

    // ageN set means holdN was captured strictly before the other, still-waiting hold.
    always_comb begin
        grant0   = 1'b0;
        grant1   = 1'b0;
        same_age = 1'b0;
        if (occ0_q && occ1_q) begin
            same_age = !age0_q && !age1_q;
            if (age0_q)      grant0 = 1'b1;
            else if (age1_q) grant1 = 1'b1;
            else if (!rr_q)  grant0 = 1'b1;
            else             grant1 = 1'b1;
        end else if (occ0_q) begin
            grant0 = 1'b1;
        end else if (occ1_q) begin
            grant1 = 1'b1;
        end
    end

    assign rdy0  = rst_n_i & (!occ0_q | grant0);
    assign rdy1  = rst_n_i & (!occ1_q | grant1);
    assign cap0  = wb.req0_valid_i & rdy0 & (wb.req0_addr_i != '0);
    assign cap1  = wb.req1_valid_i & rdy1 & (wb.req1_addr_i != '0);
    assign stay0 = occ0_q & !grant0;
    assign stay1 = occ1_q & !grant1;

    always_comb begin
        hold0_d = hold0_q;
        hold1_d = hold1_q;
        occ0_d  = cap0 | stay0;
        occ1_d  = cap1 | stay1;
        age0_d  = age0_q;
        age1_d  = age1_q;
        rr_d    = (same_age && (grant0 || grant1)) ? !rr_q : rr_q;
        we_d    = grant0 | grant1;
        waddr_d = waddr_q;
        wdata_d = wdata_q;

        if (cap0) hold0_d = {wb.req0_addr_i, wb.req0_data_i};
        if (cap1) hold1_d = {wb.req1_addr_i, wb.req1_data_i};

        // A fresh capture is always younger than whatever is still waiting.
        if (cap0 && cap1) begin
            age0_d = 1'b0;
            age1_d = 1'b0;
        end else if (cap0) begin
            age0_d = 1'b0;
            age1_d = stay1;
        end else if (cap1) begin
            age1_d = 1'b0;
            age0_d = stay0;
        end

        if (grant0) begin
            waddr_d = hold0_q.addr;
            wdata_d = hold0_q.data;
        end else if (grant1) begin
            waddr_d = hold1_q.addr;
            wdata_d = hold1_q.data;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            hold0_q <= '0;
            hold1_q <= '0;
            occ0_q  <= 1'b0;
            occ1_q  <= 1'b0;
            age0_q  <= 1'b0;
            age1_q  <= 1'b0;
            rr_q    <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            hold0_q <= hold0_d;
            hold1_q <= hold1_d;
            occ0_q  <= occ0_d;
            occ1_q  <= occ1_d;
            age0_q  <= age0_d;
            age1_q  <= age1_d;
            rr_q    <= rr_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    // The write_en term covers the half-cycle before the regfile's negedge write.
    function automatic logic pending(input logic [AW-1:0] ra);
        return (ra != '0) &&
               ((occ0_q && hold0_q.addr == ra) ||
                (occ1_q && hold1_q.addr == ra) ||
                (we_q && waddr_q == ra));
    endfunction

    assign wb.req0_ready_o = rdy0;
    assign wb.req1_ready_o = rdy1;
    assign wb.write_en_o   = we_q;
    assign wb.write_addr_o = waddr_q;
    assign wb.write_data_o = wdata_q;
    assign wb.hazard1_o    = pending(wb.read_addr1_i);
    assign wb.hazard2_o    = pending(wb.read_addr2_i);
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: timestamp-based reference model feeds a write scoreboard;
// a negedge monitor compares writes, readies and hazards, plus directed order/latency checks.
module tb_regfile_wb_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.PROC_DATA_WIDTH(16), .PROC_REGFILE_LOG2_DEEP(5)) bus ();

    regfile_wb_arbiter #(.PROC_DATA_WIDTH(16), .PROC_REGFILE_LOG2_DEEP(5)) dut (
        .clk_i  (clk),
        .rst_n_i(rst_n),
        .wb     (bus)
    );

    typedef struct packed {
        logic [4:0]  a;
        logic [15:0] d;
    } wr_t;

    wr_t exp_q[$];
    wr_t obs_q[$];
    int  obs_cyc[$];
    int  checks = 0;
    int  failures = 0;

    // Reference model: each hold remembers the cycle it was captured in.
    bit          m_occ[2] = '{1'b0, 1'b0};
    logic [4:0]  m_addr[2];
    logic [15:0] m_data[2];
    int          m_stamp[2] = '{0, 0};
    int          m_rr = 0;
    bit          m_we = 1'b0;
    logic [4:0]  m_waddr = '0;
    int          cyc = 0;

    function automatic int model_grant();
        if (m_occ[0] && m_occ[1]) begin
            if (m_stamp[0] < m_stamp[1]) return 0;
            if (m_stamp[1] < m_stamp[0]) return 1;
            return m_rr;
        end
        if (m_occ[0]) return 0;
        if (m_occ[1]) return 1;
        return -1;
    endfunction

    function automatic bit model_haz(input logic [4:0] ra);
        return (ra != 5'd0) &&
               ((m_occ[0] && m_addr[0] == ra) || (m_occ[1] && m_addr[1] == ra) ||
                (m_we && m_waddr == ra));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_occ[0] = 1'b0;
                m_occ[1] = 1'b0;
                m_rr     = 0;
                m_we     = 1'b0;
                m_waddr  = '0;
                exp_q.delete();
            end else begin : model_step
                int g;
                bit t0, t1;
                g  = model_grant();
                t0 = bus.req0_valid_i && (!m_occ[0] || g == 0);
                t1 = bus.req1_valid_i && (!m_occ[1] || g == 1);
                if (g >= 0) begin
                    if (m_occ[0] && m_occ[1] && m_stamp[0] == m_stamp[1]) m_rr = 1 - m_rr;
                    exp_q.push_back({m_addr[g], m_data[g]});
                    m_occ[g] = 1'b0;
                    m_we     = 1'b1;
                    m_waddr  = m_addr[g];
                end else begin
                    m_we = 1'b0;
                end
                if (t0 && bus.req0_addr_i != 5'd0) begin
                    m_occ[0] = 1'b1; m_addr[0] = bus.req0_addr_i;
                    m_data[0] = bus.req0_data_i; m_stamp[0] = cyc;
                end
                if (t1 && bus.req1_addr_i != 5'd0) begin
                    m_occ[1] = 1'b1; m_addr[1] = bus.req1_addr_i;
                    m_data[1] = bus.req1_data_i; m_stamp[1] = cyc;
                end
                cyc++;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            begin : mon_step
                int g;
                wr_t e;
                g = model_grant();
                chk("req0_ready", bus.req0_ready_o, rst_n && (!m_occ[0] || g == 0));
                chk("req1_ready", bus.req1_ready_o, rst_n && (!m_occ[1] || g == 1));
                chk("hazard1", bus.hazard1_o, model_haz(bus.read_addr1_i));
                chk("hazard2", bus.hazard2_o, model_haz(bus.read_addr2_i));
                chk("write_en", bus.write_en_o, exp_q.size() > 0);
                if (bus.write_en_o) begin
                    obs_q.push_back({bus.write_addr_o, bus.write_data_o});
                    obs_cyc.push_back(cyc);
                end
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    if (bus.write_en_o)
                        chk("write_addr_data", {bus.write_addr_o, bus.write_data_o}, e);
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Holds each valid until its transfer edge; returns 1 time unit after the last transfer.
    task automatic issue(input bit v0, input logic [4:0] a0, input logic [15:0] d0,
                         input bit v1, input logic [4:0] a1, input logic [15:0] d1);
        bit p0, p1, r0, r1;
        p0 = v0; p1 = v1;
        bus.req0_valid_i = v0; bus.req0_addr_i = a0; bus.req0_data_i = d0;
        bus.req1_valid_i = v1; bus.req1_addr_i = a1; bus.req1_data_i = d1;
        for (int n = 0; n < 20 && (p0 || p1); n++) begin
            @(negedge clk);
            r0 = bus.req0_ready_o;
            r1 = bus.req1_ready_o;
            @(posedge clk);
            #1;
            if (p0 && r0) begin p0 = 1'b0; bus.req0_valid_i = 1'b0; end
            if (p1 && r1) begin p1 = 1'b0; bus.req1_valid_i = 1'b0; end
        end
        if (p0 || p1) begin
            checks++; failures++;
            $display("FAIL issue_timeout actual=pending required=transferred (t=%0t)", $time);
        end
    endtask

    task automatic check_log(input string name, input wr_t e[$]);
        chk({name, "_count"}, obs_q.size(), e.size());
        for (int i = 0; i < e.size() && i < obs_q.size(); i++)
            chk(name, obs_q[i], e[i]);
    endtask

    initial begin
        wr_t e[$];
        bus.req0_valid_i = 1'b0; bus.req0_addr_i = '0; bus.req0_data_i = '0;
        bus.req1_valid_i = 1'b0; bus.req1_addr_i = '0; bus.req1_data_i = '0;
        bus.read_addr1_i = '0;   bus.read_addr2_i = '0;
        tick(3);
        chk("rst_write_addr", bus.write_addr_o, 0);
        chk("rst_write_data", bus.write_data_o, 0);
        rst_n = 1'b1;
        tick(2);

        // Single uncontended write with hazard window.
        obs_q.delete(); obs_cyc.delete();
        bus.read_addr1_i = 5'd3;
        issue(1, 5'd3, 16'h1234, 0, 5'd0, 16'h0);
        chk("haz_r3_hold", bus.hazard1_o, 1);
        tick();
        chk("haz_r3_write", bus.hazard1_o, 1);
        chk("we_r3", bus.write_en_o, 1);
        tick();
        chk("haz_r3_done", bus.hazard1_o, 0);
        tick(2);
        e.delete(); e.push_back({5'd3, 16'h1234});
        check_log("log_single", e);

        // Two same-cycle pairs: round-robin alternates.
        obs_q.delete();
        issue(1, 5'd5, 16'hAAAA, 1, 5'd6, 16'h5555);
        chk("req1_ready_waiting", bus.req1_ready_o, 0);
        tick(3);
        issue(1, 5'd5, 16'hAAAA, 1, 5'd6, 16'h5555);
        chk("req0_ready_waiting", bus.req0_ready_o, 0);
        tick(3);
        e.delete();
        e.push_back({5'd5, 16'hAAAA}); e.push_back({5'd6, 16'h5555});
        e.push_back({5'd6, 16'h5555}); e.push_back({5'd5, 16'hAAAA});
        check_log("log_rr", e);

        // Oldest-first: waiting req1 r7 beats younger req0 r7.
        obs_q.delete();
        issue(1, 5'd9, 16'h9999, 1, 5'd7, 16'h1111);
        issue(1, 5'd7, 16'h2222, 0, 5'd0, 16'h0);
        tick(4);
        e.delete();
        e.push_back({5'd9, 16'h9999}); e.push_back({5'd7, 16'h1111});
        e.push_back({5'd7, 16'h2222});
        check_log("log_oldest", e);

        // Address 0 is swallowed.
        obs_q.delete();
        bus.read_addr1_i = 5'd0;
        issue(1, 5'd0, 16'hFFFF, 0, 5'd0, 16'h0);
        chk("haz_addr0", bus.hazard1_o, 0);
        tick(3);
        e.delete();
        check_log("log_addr0", e);

        // Back-to-back stream r1..r4.
        obs_q.delete(); obs_cyc.delete();
        bus.req0_valid_i = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            bus.req0_addr_i = 5'(i);
            bus.req0_data_i = 16'h0100 + 16'(i);
            @(negedge clk);
            chk("stream_ready", bus.req0_ready_o, 1);
            tick();
        end
        bus.req0_valid_i = 1'b0;
        tick(3);
        e.delete();
        for (int i = 1; i <= 4; i++) e.push_back({5'(i), 16'h0100 + 16'(i)});
        check_log("log_stream", e);
        for (int i = 0; i + 1 < obs_cyc.size(); i++)
            chk("stream_consecutive", obs_cyc[i + 1] - obs_cyc[i], 1);

        // Asynchronous reset with hold0 occupied and a write in flight.
        obs_q.delete();
        bus.req0_valid_i = 1'b1; bus.req0_addr_i = 5'd10; bus.req0_data_i = 16'hBEEF;
        tick();
        bus.req0_addr_i = 5'd11; bus.req0_data_i = 16'hCAFE;
        tick();
        bus.req0_valid_i = 1'b0;
        bus.read_addr1_i = 5'd11; bus.read_addr2_i = 5'd10;
        chk("pre_rst_we", bus.write_en_o, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_we", bus.write_en_o, 0);
        chk("async_rst_haz1", bus.hazard1_o, 0);
        chk("async_rst_haz2", bus.hazard2_o, 0);
        chk("async_rst_ready", bus.req0_ready_o, 0);
        tick(2);
        rst_n = 1'b1;
        tick(4);
        e.delete();
        check_log("log_after_rst", e);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            bus.req0_valid_i = 1'($urandom_range(0, 1));
            bus.req0_addr_i  = 5'($urandom_range(0, 7));
            bus.req0_data_i  = 16'($urandom);
            bus.req1_valid_i = 1'($urandom_range(0, 1));
            bus.req1_addr_i  = 5'($urandom_range(0, 7));
            bus.req1_data_i  = 16'($urandom);
            bus.read_addr1_i = 5'($urandom_range(0, 7));
            bus.read_addr2_i = 5'($urandom_range(0, 7));
            tick();
        end
        bus.req0_valid_i = 1'b0;
        bus.req1_valid_i = 1'b0;
        tick(5);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters: req0 (ALU writeback) and req1 (load/memory writeback).
- Each requester has a one-entry holding register. Arbitration is oldest-first, with round-robin for same-cycle arrivals.
- Drives a registered write port into the register file. The register file samples it on the following negedge.
- Reports read-after-write hazards for the two decode read addresses, so decode can stall on values not yet written.

Parameters:
- PROC_DATA_WIDTH, 16, width of write data.
- PROC_REGFILE_LOG2_DEEP, 5, register address width (32 registers).

Ports:
- clk_i  input  1  clock; all state updates on posedge.
- rst_n_i  input  1  asynchronous active-low reset.
- req0_valid_i  input  1  req0 has a writeback.
- req0_ready_o  output  1  req0 may transfer this cycle.
- req0_addr_i  input  PROC_REGFILE_LOG2_DEEP  req0 destination register.
- req0_data_i  input  PROC_DATA_WIDTH  req0 write data.
- req1_valid_i  input  1  req1 has a writeback.
- req1_ready_o  output  1  req1 may transfer this cycle.
- req1_addr_i  input  PROC_REGFILE_LOG2_DEEP  req1 destination register.
- req1_data_i  input  PROC_DATA_WIDTH  req1 write data.
- write_en_o  output  1  register-file write enable (registered).
- write_addr_o  output  PROC_REGFILE_LOG2_DEEP  register-file write address (registered).
- write_data_o  output  PROC_DATA_WIDTH  register-file write data (registered).
- read_addr1_i  input  PROC_REGFILE_LOG2_DEEP  decode read address 1.
- read_addr2_i  input  PROC_REGFILE_LOG2_DEEP  decode read address 2.
- hazard1_o  output  1  read_addr1_i has a pending write.
- hazard2_o  output  1  read_addr2_i has a pending write.

Behaviour:
- Reset (rst_n_i low, asynchronous):
  - hold0/hold1 empty; age flags cleared; rr pointer = 0 (req0 favoured).
  - write_en_o = 0, write_addr_o = 0, write_data_o = 0.
  - req*_ready_o = 0 while rst_n_i is low; hazard*_o = 0.
- Handshake:
  - Transfer on valid & ready at posedge. The addr/data are captured into holdN and holdN becomes occupied.
  - reqN_ready_o = !holdN_occ | grantN. Never depends on reqN_valid_i.
  - Sustains one transfer per cycle per requester when that requester wins every cycle.
- Address 0:
  - A transfer with addr 0 is accepted but not stored; holdN stays empty.
  - It never produces a write and never raises a hazard.
- Arbitration (combinational over hold state each cycle):
  - Only hold0 occupied -> grant0. Only hold1 occupied -> grant1.
  - Both occupied, unequal age -> the entry captured in an earlier cycle wins (age flag).
  - Both captured in the same cycle -> the rr pointer decides; after that grant, rr flips to the other requester.
  - rr changes only on contended same-age grants.
- Write stage:
  - On posedge with a grant: write_en_o = 1, write_addr_o/write_data_o = granted entry, and the granted hold clears (unless refilled in the same edge).
  - With no grant, write_en_o = 0 and addr/data hold their last values.
  - Latency: transfer at edge N -> write_en_o high in cycle N+1 if uncontended, N+2 if it loses one arbitration.
- Refill: a granted holdN may accept a new transfer at the same edge it is granted. The new entry is marked younger than any entry still waiting.
- Same destination in both holds: the oldest-first rule preserves program order. Same-cycle captures to the same address are the producer's responsibility to avoid.
- Hazards:
  - hazardK_o = (read_addrK_i != 0) & (match hold0_occ&addr | hold1_occ&addr | write_en_o&write_addr_o).
  - The write_en_o term covers the half-cycle before the register file's negedge write; its own bypass handles reads after that.
- Reset mid-operation: pending holds and any write_en_o in flight are discarded immediately; no write occurs after reset asserts.

Test Plan:
- Reset, then req0 sends r3 = 0x1234 -> req0_ready_o = 1; next cycle write_en_o = 1, write_addr_o = 3, write_data_o = 0x1234; hazard1_o = 1 when read_addr1_i = 3 from the cycle after transfer through the write_en_o cycle.
- req0 r5 = 0xAAAA and req1 r6 = 0x5555 in the same cycle, twice in a row:
  - first pair writes r5 then r6;
  - second pair writes r6 then r5 (rr alternation);
  - req1_ready_o = 0 while hold1 waits.
- req1 r7 at cycle 0, req0 r7 at cycle 1 while the write port is busy -> r7 = req1 data written before req0 data (oldest-first).
- req0 valid with addr 0, data 0xFFFF -> ready = 1, no write_en_o pulse, hazard1_o = 0 for read_addr1_i = 0.
- Back-to-back req0 stream r1..r4, req1 idle -> write_en_o high four consecutive cycles, req0_ready_o constantly 1.
- Assert rst_n_i mid-cycle with hold0 occupied and write_en_o = 1 -> write_en_o drops asynchronously, no write after release, hazards = 0.
